// File: rtl/cayde_pkg.sv
// Shared types and defaults for the cayde core front end.
package cayde_pkg;

    localparam logic [31:0] CAYDE_RESET_PC    = 32'h0000_0000;
    localparam int          CAYDE_FETCH_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/cayde_fetch_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and decoder handshake.
interface cayde_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/cayde_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop in the same cycle.
module cayde_fetch_fifo
    import cayde_pkg::*;
#(
    parameter int DEPTH = CAYDE_FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    // Pointer/count next state; a push into a full FIFO is accepted only if a pop frees the slot.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the decoder sees zero outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/cayde_fetch.sv
// Instruction fetch unit: credit-limited word fetch, prefetch buffering and redirect flushing.
module cayde_fetch
    import cayde_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CAYDE_RESET_PC,
    parameter int          DEPTH    = CAYDE_FETCH_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    cayde_fetch_if.master   bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic          run_q, run_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    logic [CW:0]   credit_used_s;
    logic [31:0]   redirect_pc_s;
    logic          req_s, gnt_s, rsp_s, push_s, pop_s;
    fetch_entry_t  push_entry_s, head_s;

    // Request credit and response classification; a response with nothing outstanding is ignored.
    always_comb begin
        redirect_pc_s      = bus.redirect_pc & 32'hFFFF_FFFC;
        credit_used_s      = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
        req_s              = run_q && !bus.redirect_valid && (credit_used_s < DEPTH_C);
        gnt_s              = req_s && bus.imem_gnt;
        rsp_s              = bus.imem_rvalid && (outstanding_q != '0);
        push_s             = rsp_s && (discard_q == '0) && !bus.redirect_valid;
        pop_s              = !fifo_empty_s && bus.instr_ready;
        push_entry_s.pc    = resp_pc_q;
        push_entry_s.instr = bus.imem_rdata;
    end

    // Next-state for PCs and counters; a redirect re-arms discard with every response still owed.
    always_comb begin
        run_d         = 1'b1;
        outstanding_d = outstanding_q + CW'(gnt_s) - CW'(rsp_s);
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_pc_s;
            resp_pc_d  = redirect_pc_s;
            discard_d  = outstanding_q - CW'(rsp_s);
        end else begin
            if (gnt_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (rsp_s && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            run_q         <= run_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    cayde_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (bus.redirect_valid),
        .head      (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    assign bus.imem_req    = req_s;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = !fifo_empty_s;
    assign bus.instr_out   = head_s.instr;
    assign bus.instr_pc    = head_s.pc;

endmodule

// File: tb/tb_cayde_fetch.sv
// Directed bench for cayde_fetch: in-order memory model with hold control, plus a wrap-address instance.
module tb_cayde_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cayde_fetch_if bus ();
    cayde_fetch_if bus2 ();

    cayde_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cayde_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic        hold, gnt_en, b2_rec, count_gnts;
    int          stall_gnts;
    int          waited;
    logic [31:0] exp_pc;
    logic [31:0] q[$];
    logic [31:0] b2_addr[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response/grant at the negedge, commit the in-order queue at the posedge.
    task automatic cycle();
        logic        took;
        logic [31:0] a;
        bus.imem_rvalid = !hold && (q.size() > 0);
        bus.imem_rdata  = (q.size() > 0) ? word_at(q[0]) : 32'h0000_0000;
        bus.imem_gnt    = gnt_en;
        #1;
        took = bus.imem_req && bus.imem_gnt;
        a    = bus.imem_addr;
        if (b2_rec && bus2.imem_req && bus2.imem_gnt) b2_addr.push_back(bus2.imem_addr);
        if (count_gnts && took) stall_gnts++;
        @(posedge clk);
        if (bus.imem_rvalid) void'(q.pop_front());
        if (took) q.push_back(a);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        waited = 0;
        while (!bus.instr_valid && waited < 10) begin
            cycle();
            waited++;
        end
        check1(tag, bus.instr_valid, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; gnt_en = 1'b1; b2_rec = 1'b0;
        count_gnts = 1'b0; stall_gnts = 0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b1;
        bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.instr_ready = 1'b1;
        repeat (2) @(negedge clk);

        check1 ("rst_req",       bus.imem_req,    1'b0);
        check32("rst_addr",      bus.imem_addr,   32'h0000_0000);
        check1 ("rst_valid",     bus.instr_valid, 1'b0);
        check32("rst_instr",     bus.instr_out,   32'h0000_0000);
        check32("rst_pc",        bus.instr_pc,    32'h0000_0000);
        check32("rst_wrap_addr", bus2.imem_addr,  32'hFFFF_FFF8);

        // Streaming from reset with a 1-cycle memory.
        rst_n  = 1'b1;
        b2_rec = 1'b1;
        cycle();
        check1 ("c1_valid", bus.instr_valid, 1'b0);
        check1 ("c1_req",   bus.imem_req,    1'b1);
        check32("c1_addr",  bus.imem_addr,   32'h0000_0000);
        cycle();
        check1 ("c2_valid", bus.instr_valid, 1'b0);
        cycle();
        exp_pc = 32'h0000_0000;
        for (int i = 0; i < 6; i++) begin
            check1 ("stream_valid", bus.instr_valid, 1'b1);
            check32("stream_pc",    bus.instr_pc,    exp_pc);
            check32("stream_instr", bus.instr_out,   word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            cycle();
        end
        b2_rec = 1'b0;
        check32("wrap_count", 32'(b2_addr.size()), 32'd4);
        if (b2_addr.size() == 4) begin
            check32("wrap_a0", b2_addr[0], 32'hFFFF_FFF8);
            check32("wrap_a1", b2_addr[1], 32'hFFFF_FFFC);
            check32("wrap_a2", b2_addr[2], 32'h0000_0000);
            check32("wrap_a3", b2_addr[3], 32'h0000_0004);
        end

        // Decoder stall: credit cap stops requests after two more grants.
        bus.instr_ready = 1'b0;
        count_gnts = 1'b1;
        repeat (10) cycle();
        count_gnts = 1'b0;
        check32("stall_grants", 32'(stall_gnts), 32'd2);
        check1 ("stall_req",    bus.imem_req,    1'b0);
        check32("stall_addr",   bus.imem_addr,   32'h0000_0028);
        check1 ("stall_valid",  bus.instr_valid, 1'b1);
        check32("stall_pc",     bus.instr_pc,    32'h0000_0018);
        bus.instr_ready = 1'b1;
        exp_pc = 32'h0000_0018;
        for (int i = 0; i < 8; i++) begin
            check1 ("resume_valid", bus.instr_valid, 1'b1);
            check32("resume_pc",    bus.instr_pc,    exp_pc);
            check32("resume_instr", bus.instr_out,   word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            cycle();
        end

        // Redirect to 0x100 with two outstanding, one returning in the redirect cycle.
        hold = 1'b1;
        waited = 0;
        while (q.size() < 2 && waited < 10) begin
            cycle();
            waited++;
        end
        check32("redir_outstanding", 32'(q.size()), 32'd2);
        hold = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        #1;
        check1("redir_no_req", bus.imem_req, 1'b0);
        cycle();
        bus.redirect_valid = 1'b0;
        check1 ("redir_valid_r1", bus.instr_valid, 1'b0);
        #1;
        check1 ("redir_req_r1",   bus.imem_req,    1'b1);
        check32("redir_addr_r1",  bus.imem_addr,   32'h0000_0100);
        wait_valid("redir_wait");
        check32("redir_pc",    bus.instr_pc,  32'h0000_0100);
        check32("redir_instr", bus.instr_out, word_at(32'h0000_0100));
        cycle();
        check32("redir_pc_next", bus.instr_pc, 32'h0000_0104);

        // Misaligned redirect target is forced word aligned.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        cycle();
        bus.redirect_valid = 1'b0;
        check1 ("align_valid_r1", bus.instr_valid, 1'b0);
        #1;
        check32("align_addr", bus.imem_addr, 32'h0000_0200);
        wait_valid("align_wait");
        check32("align_pc",    bus.instr_pc,  32'h0000_0200);
        check32("align_instr", bus.instr_out, word_at(32'h0000_0200));
        cycle();
        check32("align_pc_next", bus.instr_pc, 32'h0000_0204);

        // Back-to-back redirects: the last target wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        cycle();
        bus.redirect_pc    = 32'h0000_0400;
        cycle();
        bus.redirect_valid = 1'b0;
        wait_valid("b2b_wait");
        check32("b2b_pc", bus.instr_pc, 32'h0000_0400);

        // Reset mid-stream with three requests in flight.
        hold = 1'b1;
        waited = 0;
        while (q.size() < 3 && waited < 10) begin
            cycle();
            waited++;
        end
        check32("mid_outstanding", 32'(q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        check1 ("mid_req",   bus.imem_req,    1'b0);
        check32("mid_addr",  bus.imem_addr,   32'h0000_0000);
        check1 ("mid_valid", bus.instr_valid, 1'b0);
        check32("mid_instr", bus.instr_out,   32'h0000_0000);
        check32("mid_pc",    bus.instr_pc,    32'h0000_0000);
        repeat (2) cycle();
        rst_n  = 1'b1;
        hold   = 1'b0;
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check1("late_rsp_valid", bus.instr_valid, 1'b0);
        end
        check32("late_drained", 32'(q.size()), 32'd0);
        check32("restart_addr", bus.imem_addr, 32'h0000_0000);
        gnt_en = 1'b1;
        wait_valid("restart_wait");
        check32("restart_pc",    bus.instr_pc,  32'h0000_0000);
        check32("restart_instr", bus.instr_out, word_at(32'h0000_0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
